// File: rtl/cdc_fifo_src_arb.sv
// Round-robin, burst-locking arbiter that multiplexes NUM_REQ source-domain
// requesters onto a single cdc_fifo source port, tagging beats with id/last.
module cdc_fifo_src_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data_i,
  input  logic [NUM_REQ-1:0]               req_last_i,
  output logic                             fifo_valid_o,
  input  logic                             fifo_ready_i,
  output logic [DATA_WIDTH-1:0]            fifo_data_o,
  output logic [ID_WIDTH-1:0]              fifo_id_o,
  output logic                             fifo_last_o,
  output logic [NUM_REQ-1:0]               grant_o,
  output logic                             busy_o
);

  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, LOCK} state_e;

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0] lock_id_q, lock_id_d;
  logic [CW-1:0]       beat_cnt_q, beat_cnt_d;

  logic [ID_WIDTH-1:0] sel, sel_next;
  logic                found, has_sel, sel_valid, sel_last, cap, hs;

  // Selection: locked id in LOCK, otherwise first valid scanning from rr_ptr.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    sel   = lock_id_q;
    idx   = 0;
    if (state_q == IDLE) begin
      sel = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        idx = 32'(rr_ptr_q) + i;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
          if (!found && idx == j && req_valid_i[j]) begin
            found = 1'b1;
            sel   = ID_WIDTH'(j);
          end
        end
      end
    end
  end

  always_comb begin
    has_sel     = (state_q == LOCK) || found;
    sel_valid   = 1'b0;
    sel_last    = 1'b0;
    fifo_data_o = '0;
    grant_o     = '0;
    req_ready_o = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (has_sel && sel == ID_WIDTH'(j)) begin
        sel_valid      = req_valid_i[j];
        sel_last       = req_last_i[j];
        fifo_data_o    = req_data_i[j*DATA_WIDTH +: DATA_WIDTH];
        grant_o[j]     = 1'b1;
        req_ready_o[j] = fifo_ready_i;
      end
    end
    cap          = (beat_cnt_q == CW'(MAX_BURST - 1));
    fifo_valid_o = sel_valid;
    fifo_id_o    = sel;
    fifo_last_o  = has_sel && (sel_last || cap);
    busy_o       = (state_q == LOCK);
    hs           = sel_valid && fifo_ready_i;
    sel_next     = (sel == ID_WIDTH'(NUM_REQ - 1)) ? '0 : sel + ID_WIDTH'(1);
  end

  // A stalled first beat still locks, so fifo_* cannot switch under backpressure.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_id_d  = lock_id_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          if (hs && fifo_last_o) begin
            rr_ptr_d   = sel_next;
            beat_cnt_d = '0;
          end else begin
            state_d   = LOCK;
            lock_id_d = sel;
            if (hs) beat_cnt_d = CW'(1);
          end
        end
      end
      LOCK: begin
        if (hs && fifo_last_o) begin
          state_d    = IDLE;
          rr_ptr_d   = sel_next;
          beat_cnt_d = '0;
        end else if (hs) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_id_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_id_q  <= lock_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule
